// File: rtl/tree_adder_sequencer.sv
// Sequences one tree-adder reduction: LOAD a source plane, SUM log2(side) passes, CAPTURE pixel [0][0], then hold it for a ready/valid handshake.
// Optional accumulator of captured sums is enabled by defining TREE_ADDER_SEQ_ACC_EN.
module tree_adder_sequencer #(
    parameter int IMGSIDELENGTH  = 64,
    parameter int ADDER_DATASIZE = 16,
    parameter int CMD_WIDTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [1:0]                    src_sel,
    input  logic [ADDER_DATASIZE-1:0]     sum_in,
    output logic [CMD_WIDTH-1:0]          cmd_out,
    output logic                          busy,
    output logic [ADDER_DATASIZE-1:0]     result,
    output logic                          result_valid,
    input  logic                          result_ready
`ifdef TREE_ADDER_SEQ_ACC_EN
    ,
    input  logic                          acc_clr,
    output logic [2*ADDER_DATASIZE-1:0]   acc_out
`endif
);

    localparam int PASSES = $clog2(IMGSIDELENGTH);
    localparam int CNT_W  = $clog2(PASSES) + 1;

    localparam logic [CMD_WIDTH-1:0] CMD_IDLE = CMD_WIDTH'(0);
    localparam logic [CMD_WIDTH-1:0] CMD_LOAD = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] CMD_SUM  = CMD_WIDTH'(4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SUM,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     pass_cnt;
    logic [CMD_WIDTH-1:0] cmd_nxt;
    logic                 last_pass;

    assign last_pass = (pass_cnt == CNT_W'(PASSES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cmd_out <= CMD_IDLE;
        end else begin
            state   <= state_nxt;
            cmd_out <= cmd_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start && (src_sel != 2'd3)) state_nxt = S_LOAD;
            S_LOAD:    state_nxt = S_SUM;
            S_SUM:     if (last_pass) state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_DONE;
            S_DONE:    if (result_ready) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // LOAD is only entered from IDLE, so src_sel here is the value sampled with start.
    always_comb begin
        cmd_nxt      = CMD_IDLE;
        busy         = (state != S_IDLE);
        result_valid = (state == S_DONE);
        case (state_nxt)
            S_LOAD:  cmd_nxt = CMD_LOAD + CMD_WIDTH'(src_sel);
            S_SUM:   cmd_nxt = CMD_SUM;
            default: cmd_nxt = CMD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt <= '0;
        end else if (state == S_SUM) begin
            pass_cnt <= pass_cnt + CNT_W'(1);
        end else begin
            pass_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
        end else if (state == S_CAPTURE) begin
            result <= sum_in;
        end
    end

`ifdef TREE_ADDER_SEQ_ACC_EN
    logic [2*ADDER_DATASIZE-1:0] sum_ext;
    assign sum_ext = {{ADDER_DATASIZE{1'b0}}, sum_in};

    // A clear coinciding with a capture restarts the total from this capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_out <= '0;
        end else if (state == S_CAPTURE) begin
            acc_out <= acc_clr ? sum_ext : (acc_out + sum_ext);
        end else if (acc_clr) begin
            acc_out <= '0;
        end
    end
`endif

endmodule
